mac_array_engine: RTL
=====================

// Module: mac_array_engine
// PURPOSE
//   Parametrised ROWS x COLS outer-product MAC array for the CNN datapath; next generation of the 16x16 MAC core.
//   Per-column weight buffers are loaded in IDLE. A start command runs cfg_k accumulation steps over a valid/ready
//   data stream. Result rows then drain one per beat on a valid/ready output port. Adds signed saturation and backpressure.
// PARAMETERS
//   ROWS        16  data lanes (array rows); ROWS >= 2 for out_row width
//   COLS        16  weight lanes (array columns)
//   DATA_W       8  signed data width
//   WEIGHT_W     8  signed weight width
//   ACC_W       20  signed accumulator width; ACC_W >= DATA_W+WEIGHT_W
//   WBUF_DEPTH  32  weight-buffer entries per column; max accumulation length
//   SATURATE     1  1 = saturating accumulate, 0 = two's-complement wrap
//   (derived) AW=$clog2(WBUF_DEPTH), KW=$clog2(WBUF_DEPTH+1), RW=$clog2(ROWS)
// PORTS
//   Clk        in   1               clock; all logic on posedge
//   reset      in   1               synchronous, active-high reset
//   wr_en      in   1               weight write strobe
//   wr_addr    in   AW              weight-buffer address
//   wr_data    in   COLS*WEIGHT_W   one weight per column; col c at [c*WEIGHT_W +: WEIGHT_W]
//   wr_ready   out  1               1 in IDLE only; writes are accepted only when wr_en && wr_ready
//   cfg_k      in   KW              accumulation length; sampled on start
//   start      in   1               begin a run; honoured only in IDLE
//   cfg_err    out  1               1-cycle pulse: start with cfg_k==0 or cfg_k>WBUF_DEPTH
//   busy       out  1               high in every state except IDLE
//   in_valid   in   1               data beat valid
//   in_ready   out  1               1 in ACCUM only
//   in_data    in   ROWS*DATA_W     row r at [r*DATA_W +: DATA_W]
//   out_valid  out  1               result row valid
//   out_ready  in   1               result row accepted
//   out_row    out  RW              row index of out_data
//   out_data   out  COLS*ACC_W      accumulators of row out_row; col c at [c*ACC_W +: ACC_W]
//   out_last   out  1               high with out_valid on row ROWS-1
//   sat_flag   out  1               sticky: any accumulator saturated this run; cleared by reset and accepted start
// BEHAVIOUR
//   - Reset values: state IDLE, all accumulators 0, k_cnt 0, every output 0 except wr_ready=1.
//     Weight buffers are NOT cleared by reset; contents are undefined until written.
//   - FSM IDLE->ACCUM on start with valid cfg_k. Same edge: zero accumulators, zero k_cnt, latch cfg_k, clear sat_flag.
//     An invalid cfg_k pulses cfg_err and stays IDLE. start outside IDLE is ignored.
//   - ACCUM: each accepted beat (in_valid && in_ready) reads weight address k_cnt, then k_cnt++.
//     Once beat k_cnt==cfg_k-1 is accepted, in_ready drops the next cycle and the FSM enters FLUSH.
//   - Pipeline: beat accepted at cycle t is registered with its weights (synchronous read) at t.
//     acc[r][c] += data[r]*w[c] is applied at t+1. FLUSH is a single cycle; DRAIN begins at t+2 after the last beat.
//   - DRAIN: out_valid=1, rows emitted in order 0..ROWS-1, advancing on out_valid && out_ready.
//     out_row/out_data/out_last hold stable while stalled. Acceptance of the out_last beat -> IDLE, out_valid=0 next cycle.
//   - Arithmetic: signed product is DATA_W+WEIGHT_W bits, sign-extended to ACC_W.
//     SATURATE=1 clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets sat_flag. SATURATE=0 wraps and never sets sat_flag.
//   - wr_en && start in the same IDLE cycle: the write commits first and is visible to the run.
//   - wr_en outside IDLE is dropped with no buffer change.
//   - in_valid outside ACCUM is ignored. Gaps in in_valid stall k_cnt with no accumulation.
//   - Reset mid-run (any state) -> IDLE next cycle; accumulators zeroed; no partial rows emitted.
// STRUCTURE
//   - Package mac_pkg: state enum {IDLE,ACCUM,FLUSH,DRAIN}, width localparam helpers, function sat_add(a,b,sat_en).
//   - Sub-module mac_pe: one signed MAC cell with clear, enable, SATURATE and a saturation-event output.
//     ROWS*COLS instances via generate.
//   - Top holds the FSM, k_cnt, row counter, COLS weight-buffer RAMs (inferable) and the output row mux.
// TESTING (bench override ROWS=2, COLS=2, ACC_W=16, WBUF_DEPTH=4 unless noted)
//   1 Reset 2 cycles -> busy=0, in_ready=0, out_valid=0, sat_flag=0, wr_ready=1.
//   2 w[0]={1,2}, w[1]={3,4}, w[2]={-1,0}; cfg_k=3; beats {1,1},{2,-1},{5,0}
//     -> row0={2,10}, row1={-2,-2}; out_last on row1; first out_valid 2 cycles after last beat.
//   3 Saturation: w=127 all cols; cfg_k=3 with data 127 -> 32767 and sat_flag=1; data -128 -> -32768.
//     Same run with SATURATE=0 -> wrapped values, sat_flag=0.
//   4 Backpressure: repeat test 2 with random in_valid gaps and out_ready low 5 cycles mid-drain
//     -> identical rows, out_data stable while stalled, exactly 2 output beats.
//   5 Boundaries: start with cfg_k=0 and with cfg_k=5 -> cfg_err pulse, busy stays 0. start during ACCUM ignored.
//     wr_en during ACCUM leaves buffer unchanged (checked by a follow-up run).
//   6 Reset after 2 beats of test 2 -> IDLE next cycle, no out_valid. Rerun test 2 -> same results (weights retained).

Source files
------------

// File: rtl/mac_array_engine_pkg.sv
// Shared types and arithmetic helpers for the outer-product MAC array.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int SAT_W = 64;

    typedef logic signed [SAT_W-1:0] wide_t;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] sum;
    } sat_res_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int row_w(input int rows);
        return $clog2(rows);
    endfunction

    // Adds at full width, then clamps to the acc_w-bit signed range when enabled;
    // with clamping off the caller's truncation to acc_w bits provides the wrap.
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                         input logic sat_en, input int acc_w);
        wide_t    s;
        wide_t    hi;
        wide_t    lo;
        sat_res_t r;
        s     = a + b;
        hi    = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
        lo    = -hi - wide_t'(1);
        r.sat = 1'b0;
        r.sum = s;
        if (sat_en) begin
            if (s > hi) begin
                r.sum = hi;
                r.sat = 1'b1;
            end else if (s < lo) begin
                r.sum = lo;
                r.sat = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_array_engine_if.sv
// Weight-load, command, input-stream and result-stream bus of the MAC array engine.
interface mac_array_engine_if #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int ACC_W      = 20,
    parameter int WBUF_DEPTH = 32
) ();
    import mac_pkg::*;

    localparam int AW = addr_w(WBUF_DEPTH);
    localparam int KW = cnt_w(WBUF_DEPTH);
    localparam int RW = row_w(ROWS);

    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [COLS*WEIGHT_W-1:0] wr_data;
    logic                     wr_ready;
    logic [KW-1:0]            cfg_k;
    logic                     start;
    logic                     cfg_err;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [RW-1:0]            out_row;
    logic [COLS*ACC_W-1:0]    out_data;
    logic                     out_last;
    logic                     sat_flag;

    modport master (
        output wr_en, wr_addr, wr_data, cfg_k, start, in_valid, in_data, out_ready,
        input  wr_ready, cfg_err, busy, in_ready, out_valid, out_row, out_data, out_last, sat_flag
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, cfg_k, start, in_valid, in_data, out_ready,
        output wr_ready, cfg_err, busy, in_ready, out_valid, out_row, out_data, out_last, sat_flag
    );

endinterface

// File: rtl/mac_array_engine_pe.sv
// Single signed multiply-accumulate cell with synchronous clear and optional saturation.
module mac_pe
    import mac_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20,
    parameter int SATURATE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   data_i,
    input  logic signed [WEIGHT_W-1:0] weight_i,
    output logic signed [ACC_W-1:0]    acc_o,
    output logic                       sat_evt_o
);

    localparam int PW = DATA_W + WEIGHT_W;

    logic signed [PW-1:0]    prod;
    sat_res_t                res;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        prod      = PW'(data_i) * PW'(weight_i);
        res       = sat_add(wide_t'(prod), wide_t'(acc_q), SATURATE != 0, ACC_W);
        acc_d     = acc_q;
        sat_evt_o = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d     = ACC_W'(res.sum);
            sat_evt_o = res.sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mac_array_engine.sv
// ROWS x COLS outer-product MAC array: per-column weight RAMs, k-step accumulate over a
// valid/ready stream, then one result row per beat on a valid/ready output.
module mac_array_engine
    import mac_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int ACC_W      = 20,
    parameter int WBUF_DEPTH = 32,
    parameter int SATURATE   = 1
) (
    input logic              Clk,
    input logic              reset,
    mac_array_engine_if.slave bus
);

    localparam int AW = addr_w(WBUF_DEPTH);
    localparam int KW = cnt_w(WBUF_DEPTH);
    localparam int RW = row_w(ROWS);

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_cnt_q, k_cnt_d;
    logic [KW-1:0]          k_len_q, k_len_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   sat_flag_q, sat_flag_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   vld_p1_q, vld_p1_d;
    logic [ROWS*DATA_W-1:0] data_p1_q, data_p1_d;

    logic signed [WEIGHT_W-1:0] w_p1_q   [COLS];
    logic signed [WEIGHT_W-1:0] wbuf_mem [COLS][WBUF_DEPTH];
    logic signed [ACC_W-1:0]    acc      [ROWS][COLS];
    logic [ROWS*COLS-1:0]       sat_evt;

    logic cfg_bad;
    logic start_ok;
    logic accept;
    logic wr_ok;

    always_comb begin
        cfg_bad  = (bus.cfg_k == '0) || (bus.cfg_k > KW'(WBUF_DEPTH));
        start_ok = (state_q == IDLE) && bus.start && !cfg_bad;
        accept   = (state_q == ACCUM) && bus.in_valid;
        wr_ok    = (state_q == IDLE) && bus.wr_en;
    end

    always_comb begin
        state_d    = state_q;
        k_cnt_d    = k_cnt_q;
        k_len_d    = k_len_q;
        row_d      = row_q;
        sat_flag_d = sat_flag_q | (|sat_evt);
        cfg_err_d  = 1'b0;
        vld_p1_d   = accept;
        data_p1_d  = accept ? bus.in_data : data_p1_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d    = ACCUM;
                        k_cnt_d    = '0;
                        k_len_d    = bus.cfg_k;
                        sat_flag_d = 1'b0;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    k_cnt_d = k_cnt_q + KW'(1);
                    if (k_cnt_q == k_len_q - KW'(1)) state_d = FLUSH;
                end
            end
            // FLUSH lets the last registered beat land in the accumulators.
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (bus.out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_cnt_q    <= '0;
            k_len_q    <= '0;
            row_q      <= '0;
            sat_flag_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            vld_p1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_cnt_q    <= k_cnt_d;
            k_len_q    <= k_len_d;
            row_q      <= row_d;
            sat_flag_q <= sat_flag_d;
            cfg_err_q  <= cfg_err_d;
            vld_p1_q   <= vld_p1_d;
        end
    end

    // Stage p1: accepted beat registered together with its synchronously read weights.
    always_ff @(posedge Clk) begin
        data_p1_q <= data_p1_d;
        for (int c = 0; c < COLS; c++) begin
            if (wr_ok) wbuf_mem[c][bus.wr_addr] <= bus.wr_data[c*WEIGHT_W +: WEIGHT_W];
            if (accept) w_p1_q[c] <= wbuf_mem[c][k_cnt_q[AW-1:0]];
        end
    end

    // Stage p2: every cell accumulates data[r] * w[c].
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_pe #(
                .DATA_W   (DATA_W),
                .WEIGHT_W (WEIGHT_W),
                .ACC_W    (ACC_W),
                .SATURATE (SATURATE)
            ) u_pe (
                .clk       (Clk),
                .rst       (reset),
                .clr       (start_ok),
                .en        (vld_p1_q),
                .data_i    (data_p1_q[r*DATA_W +: DATA_W]),
                .weight_i  (w_p1_q[c]),
                .acc_o     (acc[r][c]),
                .sat_evt_o (sat_evt[r*COLS + c])
            );
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < COLS; c++) bus.out_data[c*ACC_W +: ACC_W] = acc[row_q][c];
    end

    assign bus.wr_ready  = (state_q == IDLE);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_row   = row_q;
    assign bus.out_last  = (state_q == DRAIN) && (row_q == RW'(ROWS - 1));
    assign bus.cfg_err   = cfg_err_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule
